// File: rtl/scr1_pipe_pkg.sv
// Shared pipeline definitions for the MPRF writeback controller slice:
// architectural widths and the writeback-controller state encoding.
package scr1_pipe_pkg;

  localparam int unsigned SCR1_MPRF_ADDR_WIDTH = 5;
  localparam int unsigned SCR1_XLEN            = 32;

  // IDLE: no long-latency result outstanding; PEND: one long result owed to pend_addr
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } type_scr1_wbctrl_state_e;

  // True when the controller is waiting on a long-latency writeback
  function automatic logic scr1_wbctrl_is_pend(input type_scr1_wbctrl_state_e st);
    return (st == PEND) ? 1'b1 : 1'b0;
  endfunction

endpackage : scr1_pipe_pkg

// File: rtl/scr1_pipe_mprf_bypass.sv
// One operand path: compares a source address against the pending long
// destination and selects between the forwarded long result and MPRF data.
// x0 always reads as zero regardless of what the register file returns.
module scr1_pipe_mprf_bypass #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic              pend_vld,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              fwd_vld,
  input  logic [XLEN-1:0]   fwd_data,
  input  logic [XLEN-1:0]   mprf_data,
  output logic              rs_hit,
  output logic [XLEN-1:0]   rs_data
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [XLEN-1:0]   DATA_ZERO = {XLEN{1'b0}};

  logic rs_is_x0_s;
  logic hit_s;

  // Hit against the pending destination; x0 never hits since it is never written
  always_comb begin
    rs_is_x0_s = (rs_addr == ADDR_ZERO);
    hit_s      = 1'b0;
    if (pend_vld && (rs_addr == pend_addr) && !rs_is_x0_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Operand select: x0 forced to zero, then same-cycle long result, then MPRF
  always_comb begin
    rs_hit  = hit_s;
    rs_data = DATA_ZERO;
    if (rs_is_x0_s) begin
      rs_data = DATA_ZERO;
    end else if (fwd_vld && hit_s) begin
      rs_data = fwd_data;
    end else begin
      rs_data = mprf_data;
    end
  end

endmodule : scr1_pipe_mprf_bypass

// File: rtl/scr1_pipe_mprf_wb_ctrl.sv
// EXU-side MPRF writeback controller and hazard scoreboard. Tracks at most one
// outstanding long-latency destination, stalls issue on hazards against it,
// forwards the long result to operands in its return cycle, and arbitrates the
// single MPRF write port (the long result wins over a same-cycle ALU result).
module scr1_pipe_mprf_wb_ctrl
  import scr1_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = SCR1_MPRF_ADDR_WIDTH,
  parameter int unsigned XLEN   = SCR1_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  // Issue interface
  input  logic              exu_issue_vld,
  input  logic [ADDR_W-1:0] exu_rs1_addr,
  input  logic [ADDR_W-1:0] exu_rs2_addr,
  input  logic              exu_rs1_used,
  input  logic              exu_rs2_used,
  input  logic              exu_rd_wr,
  input  logic [ADDR_W-1:0] exu_rd_addr,
  input  logic              exu_rd_long,
  input  logic [XLEN-1:0]   exu_rd_data,
  output logic              exu_issue_stall,
  output logic [XLEN-1:0]   exu_rs1_data,
  output logic [XLEN-1:0]   exu_rs2_data,
  // Long-latency result return
  input  logic              long_wb_vld,
  input  logic              long_wb_err,
  input  logic [XLEN-1:0]   long_wb_data,
  input  logic              exu_kill,
  // MPRF interface
  output logic [ADDR_W-1:0] exu2mprf_rs1_addr,
  output logic [ADDR_W-1:0] exu2mprf_rs2_addr,
  input  logic [XLEN-1:0]   mprf2exu_rs1_data,
  input  logic [XLEN-1:0]   mprf2exu_rs2_data,
  output logic              exu2mprf_w_req,
  output logic [ADDR_W-1:0] exu2mprf_rd_addr,
  output logic [XLEN-1:0]   exu2mprf_rd_data
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [XLEN-1:0]   DATA_ZERO = {XLEN{1'b0}};

  type_scr1_wbctrl_state_e state_r;
  logic [ADDR_W-1:0]       pend_addr_r;

  logic              pend_s;
  logic              wb_done_s;
  logic              wb_fwd_s;
  logic              rs1_hit_s;
  logic              rs2_hit_s;
  logic              rd_hit_s;
  logic              rd_nz_s;
  logic              stall_hz_s;
  logic              stall_port_s;
  logic              stall_s;
  logic              issue_acc_s;
  logic              alu_wr_s;
  logic              w_req_s;
  logic [ADDR_W-1:0] w_addr_s;
  logic [XLEN-1:0]   w_data_s;

  // MPRF read addresses are a straight passthrough of the source fields
  assign exu2mprf_rs1_addr = exu_rs1_addr;
  assign exu2mprf_rs2_addr = exu_rs2_addr;

  scr1_pipe_mprf_bypass #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) i_bypass_rs1 (
    .pend_vld  (pend_s),
    .pend_addr (pend_addr_r),
    .rs_addr   (exu_rs1_addr),
    .fwd_vld   (wb_fwd_s),
    .fwd_data  (long_wb_data),
    .mprf_data (mprf2exu_rs1_data),
    .rs_hit    (rs1_hit_s),
    .rs_data   (exu_rs1_data)
  );

  scr1_pipe_mprf_bypass #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) i_bypass_rs2 (
    .pend_vld  (pend_s),
    .pend_addr (pend_addr_r),
    .rs_addr   (exu_rs2_addr),
    .fwd_vld   (wb_fwd_s),
    .fwd_data  (long_wb_data),
    .mprf_data (mprf2exu_rs2_data),
    .rs_hit    (rs2_hit_s),
    .rs_data   (exu_rs2_data)
  );

  // Scoreboard status: pending flag, long result return and destination hit
  always_comb begin
    pend_s    = scr1_wbctrl_is_pend(state_r);
    wb_done_s = pend_s & long_wb_vld;
    wb_fwd_s  = wb_done_s & ~long_wb_err;
    rd_nz_s   = (exu_rd_addr != ADDR_ZERO);
    rd_hit_s  = 1'b0;
    if (pend_s && (exu_rd_addr == pend_addr_r) && rd_nz_s) begin
      rd_hit_s = 1'b1;
    end else begin
      rd_hit_s = 1'b0;
    end
  end

  // Issue stall: hazard on the pending destination, second long op, or write-port
  // conflict with a returning long result; forced low while in reset
  always_comb begin
    stall_hz_s   = exu_issue_vld & pend_s & ~wb_done_s &
                   ((exu_rs1_used & rs1_hit_s) | (exu_rs2_used & rs2_hit_s) |
                    (exu_rd_wr & rd_hit_s) | exu_rd_long);
    stall_port_s = exu_issue_vld & wb_done_s & exu_rd_wr & ~exu_rd_long & rd_nz_s;
    stall_s      = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_hz_s | stall_port_s;
    end
    issue_acc_s  = exu_issue_vld & ~stall_s;
    alu_wr_s     = issue_acc_s & exu_rd_wr & ~exu_rd_long & rd_nz_s;
  end

  // Write-port arbitration: long result first, then single-cycle result; kill
  // and reset suppress every write in that cycle
  always_comb begin
    w_req_s  = 1'b0;
    w_addr_s = ADDR_ZERO;
    w_data_s = DATA_ZERO;
    if (!rst_n || exu_kill) begin
      w_req_s = 1'b0;
    end else if (wb_fwd_s && (pend_addr_r != ADDR_ZERO)) begin
      w_req_s  = 1'b1;
      w_addr_s = pend_addr_r;
      w_data_s = long_wb_data;
    end else if (alu_wr_s) begin
      w_req_s  = 1'b1;
      w_addr_s = exu_rd_addr;
      w_data_s = exu_rd_data;
    end else begin
      w_req_s = 1'b0;
    end
  end

  assign exu_issue_stall  = stall_s;
  assign exu2mprf_w_req   = w_req_s;
  assign exu2mprf_rd_addr = w_addr_s;
  assign exu2mprf_rd_data = w_data_s;

  // Pending-destination FSM: enter on an accepted long issue (even to x0, whose
  // write is later dropped), leave on the long return or a kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pend_addr_r <= ADDR_ZERO;
    end else if (exu_kill) begin
      state_r     <= IDLE;
      pend_addr_r <= pend_addr_r;
    end else if (issue_acc_s && exu_rd_wr && exu_rd_long) begin
      state_r     <= PEND;
      pend_addr_r <= exu_rd_addr;
    end else if (wb_done_s) begin
      state_r     <= IDLE;
      pend_addr_r <= pend_addr_r;
    end else begin
      state_r     <= state_r;
      pend_addr_r <= pend_addr_r;
    end
  end

endmodule : scr1_pipe_mprf_wb_ctrl

// File: tb/tb_scr1_pipe_mprf_wb_ctrl.sv
// Testbench for scr1_pipe_mprf_wb_ctrl: directed scenarios followed by a
// randomized run, all checked against a scoreboard model of one pending
// long destination and a bench-owned register file.
module tb_scr1_pipe_mprf_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        exu_issue_vld;
  logic [4:0]  exu_rs1_addr, exu_rs2_addr;
  logic        exu_rs1_used, exu_rs2_used;
  logic        exu_rd_wr;
  logic [4:0]  exu_rd_addr;
  logic        exu_rd_long;
  logic [31:0] exu_rd_data;
  logic        exu_issue_stall;
  logic [31:0] exu_rs1_data, exu_rs2_data;
  logic        long_wb_vld, long_wb_err;
  logic [31:0] long_wb_data;
  logic        exu_kill;
  logic [4:0]  exu2mprf_rs1_addr, exu2mprf_rs2_addr;
  logic [31:0] mprf2exu_rs1_data, mprf2exu_rs2_data;
  logic        exu2mprf_w_req;
  logic [4:0]  exu2mprf_rd_addr;
  logic [31:0] exu2mprf_rd_data;

  // Register file contents as the bench believes them; x0 holds junk on purpose
  logic [31:0] mem [32];
  assign mprf2exu_rs1_data = mem[exu2mprf_rs1_addr];
  assign mprf2exu_rs2_data = mem[exu2mprf_rs2_addr];

  int checks   = 0;
  int failures = 0;

  // Scoreboard model: is a long result owed, and to which register
  bit       m_pend;
  bit [4:0] m_dst;
  bit       e_wreq, e_acc;
  bit [4:0] e_waddr;
  bit [31:0] e_wdata;

  scr1_pipe_mprf_wb_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exu_issue_vld     (exu_issue_vld),
    .exu_rs1_addr      (exu_rs1_addr),
    .exu_rs2_addr      (exu_rs2_addr),
    .exu_rs1_used      (exu_rs1_used),
    .exu_rs2_used      (exu_rs2_used),
    .exu_rd_wr         (exu_rd_wr),
    .exu_rd_addr       (exu_rd_addr),
    .exu_rd_long       (exu_rd_long),
    .exu_rd_data       (exu_rd_data),
    .exu_issue_stall   (exu_issue_stall),
    .exu_rs1_data      (exu_rs1_data),
    .exu_rs2_data      (exu_rs2_data),
    .long_wb_vld       (long_wb_vld),
    .long_wb_err       (long_wb_err),
    .long_wb_data      (long_wb_data),
    .exu_kill          (exu_kill),
    .exu2mprf_rs1_addr (exu2mprf_rs1_addr),
    .exu2mprf_rs2_addr (exu2mprf_rs2_addr),
    .mprf2exu_rs1_data (mprf2exu_rs1_data),
    .mprf2exu_rs2_data (mprf2exu_rs2_data),
    .exu2mprf_w_req    (exu2mprf_w_req),
    .exu2mprf_rd_addr  (exu2mprf_rd_addr),
    .exu2mprf_rd_data  (exu2mprf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit blocked(input bit [4:0] r);
    return m_pend && (r == m_dst) && (r != 5'd0);
  endfunction

  function automatic bit [31:0] operand(input bit [4:0] r, input bit fwd);
    if (r == 5'd0) return 32'd0;
    if (fwd && blocked(r)) return long_wb_data;
    return mem[r];
  endfunction

  // Mid-cycle: compute what the design owes this cycle and compare
  task automatic mid(input string tag);
    bit returning, fwd, hazard, conflict, e_stall;
    @(negedge clk);
    if (!rst_n) begin m_pend = 1'b0; m_dst = 5'd0; end
    returning = m_pend && long_wb_vld;
    fwd       = returning && !long_wb_err;
    hazard    = m_pend && !returning &&
                ((exu_rs1_used && blocked(exu_rs1_addr)) || (exu_rs2_used && blocked(exu_rs2_addr)) ||
                 (exu_rd_wr && blocked(exu_rd_addr)) || exu_rd_long);
    conflict  = returning && exu_rd_wr && !exu_rd_long && (exu_rd_addr != 5'd0);
    e_stall   = rst_n && exu_issue_vld && (hazard || conflict);
    e_acc     = exu_issue_vld && !e_stall;
    e_wreq = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
    if (rst_n && !exu_kill) begin
      if (fwd && m_dst != 5'd0) begin
        e_wreq = 1'b1; e_waddr = m_dst; e_wdata = long_wb_data;
      end else if (e_acc && exu_rd_wr && !exu_rd_long && exu_rd_addr != 5'd0) begin
        e_wreq = 1'b1; e_waddr = exu_rd_addr; e_wdata = exu_rd_data;
      end
    end
    chk({tag, ":stall"}, {31'd0, exu_issue_stall}, {31'd0, e_stall});
    chk({tag, ":ra1"}, {27'd0, exu2mprf_rs1_addr}, {27'd0, exu_rs1_addr});
    chk({tag, ":ra2"}, {27'd0, exu2mprf_rs2_addr}, {27'd0, exu_rs2_addr});
    chk({tag, ":rs1"}, exu_rs1_data, operand(exu_rs1_addr, fwd));
    chk({tag, ":rs2"}, exu_rs2_data, operand(exu_rs2_addr, fwd));
    chk({tag, ":wreq"}, {31'd0, exu2mprf_w_req}, {31'd0, e_wreq});
    if (e_wreq) begin
      chk({tag, ":waddr"}, {27'd0, exu2mprf_rd_addr}, {27'd0, e_waddr});
      chk({tag, ":wdata"}, exu2mprf_rd_data, e_wdata);
    end
  endtask

  // Clock edge: commit the register write and advance the pending record
  task automatic edge_();
    bit returning;
    @(posedge clk);
    returning = m_pend && long_wb_vld;
    if (!rst_n) begin
      m_pend = 1'b0; m_dst = 5'd0;
    end else begin
      if (e_wreq) mem[e_waddr] = e_wdata;
      if (exu_kill) m_pend = 1'b0;
      else if (e_acc && exu_rd_wr && exu_rd_long) begin m_pend = 1'b1; m_dst = exu_rd_addr; end
      else if (returning) m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic issue(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2,
                       input bit wr, input bit [4:0] rd, input bit lng, input bit [31:0] d);
    exu_issue_vld = v; exu_rs1_addr = r1; exu_rs1_used = u1; exu_rs2_addr = r2; exu_rs2_used = u2;
    exu_rd_wr = wr; exu_rd_addr = rd; exu_rd_long = lng; exu_rd_data = d;
  endtask

  task automatic lwb(input bit v, input bit e, input bit [31:0] d);
    long_wb_vld = v; long_wb_err = e; long_wb_data = d;
  endtask

  logic [31:0] old4;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'hBAD0_0000;
    m_pend = 1'b0; m_dst = 5'd0;
    exu_kill = 1'b0;
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h1111_1111);
    lwb(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #2;
    // Reset: stall and write request held low even with an ALU issue present
    mid("reset");
    chk("reset_wreq", {31'd0, exu2mprf_w_req}, 32'd0);
    chk("reset_stall", {31'd0, exu_issue_stall}, 32'd0);
    edge_();
    rst_n = 1'b1;

    // ALU write to x5, then read it back
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF);
    mid("alu5");
    chk("alu5_wreq", {31'd0, exu2mprf_w_req}, 32'd1);
    chk("alu5_waddr", {27'd0, exu2mprf_rd_addr}, 32'd5);
    edge_();
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    mid("rd5");
    chk("rd5_data", exu_rs1_data, 32'hDEAD_BEEF);
    edge_();

    // Load to x7; consumer of x7 stalls until the result returns, then bypasses
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 32'd0);
    mid("ld7"); edge_();
    issue(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    mid("use7a"); chk("use7a_stall", {31'd0, exu_issue_stall}, 32'd1); edge_();
    mid("use7b"); chk("use7b_stall", {31'd0, exu_issue_stall}, 32'd1); edge_();
    lwb(1'b1, 1'b0, 32'h0000_1234);
    mid("wb7");
    chk("wb7_stall", {31'd0, exu_issue_stall}, 32'd0);
    chk("wb7_byp", exu_rs2_data, 32'h0000_1234);
    chk("wb7_waddr", {27'd0, exu2mprf_rd_addr}, 32'd7);
    edge_();
    lwb(1'b0, 1'b0, 32'd0);

    // Port conflict: long to x3 returns while ALU wants x9
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 32'd0);
    mid("ld3"); edge_();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0000_0099);
    lwb(1'b1, 1'b0, 32'h0000_3333);
    mid("conf");
    chk("conf_stall", {31'd0, exu_issue_stall}, 32'd1);
    chk("conf_waddr", {27'd0, exu2mprf_rd_addr}, 32'd3);
    edge_();
    lwb(1'b0, 1'b0, 32'd0);
    mid("alu9");
    chk("alu9_waddr", {27'd0, exu2mprf_rd_addr}, 32'd9);
    chk("alu9_wdata", exu2mprf_rd_data, 32'h0000_0099);
    edge_();

    // Faulting long op to x4: no write, x4 keeps its old value
    old4 = mem[4];
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'd0);
    mid("ld4"); edge_();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    lwb(1'b1, 1'b1, 32'h4444_4444);
    mid("err4"); chk("err4_wreq", {31'd0, exu2mprf_w_req}, 32'd0); edge_();
    lwb(1'b0, 1'b0, 32'd0);
    issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    mid("rd4");
    chk("rd4_data", exu_rs1_data, old4);
    chk("rd4_stall", {31'd0, exu_issue_stall}, 32'd0);
    edge_();

    // Kill drops the pending x6 write
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 32'd0);
    mid("ld6"); edge_();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    exu_kill = 1'b1;
    mid("kill"); edge_();
    exu_kill = 1'b0;
    lwb(1'b1, 1'b0, 32'h6666_6666);
    mid("post_kill"); chk("post_kill_wreq", {31'd0, exu2mprf_w_req}, 32'd0); edge_();
    lwb(1'b0, 1'b0, 32'd0);

    // Reset while x8 is pending
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 32'd0);
    mid("ld8"); edge_();
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h5555_5555);
    lwb(1'b1, 1'b0, 32'h8888_8888);
    rst_n = 1'b0;
    #1;
    chk("rstpend_wreq", {31'd0, exu2mprf_w_req}, 32'd0);
    chk("rstpend_stall", {31'd0, exu_issue_stall}, 32'd0);
    mid("rstpend"); edge_();
    rst_n = 1'b1;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    mid("post_rst"); chk("post_rst_wreq", {31'd0, exu2mprf_w_req}, 32'd0); edge_();
    lwb(1'b0, 1'b0, 32'd0);

    // x0 destinations never write; x0 sources never stall and read as zero
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF);
    mid("alu0"); chk("alu0_wreq", {31'd0, exu2mprf_w_req}, 32'd0); edge_();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 32'd0);
    mid("ld0"); edge_();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0000_00AA);
    mid("use0");
    chk("use0_stall", {31'd0, exu_issue_stall}, 32'd0);
    chk("use0_rs1", exu_rs1_data, 32'd0);
    edge_();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    lwb(1'b1, 1'b0, 32'h0000_0BAD);
    mid("wb0"); chk("wb0_wreq", {31'd0, exu2mprf_w_req}, 32'd0); edge_();
    lwb(1'b0, 1'b0, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom);
      lwb($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom);
      exu_kill = ($urandom_range(0, 15) == 0);
      if (exu_kill) exu_issue_vld = 1'b0;
      mid("rand");
      edge_();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scr1_pipe_mprf_wb_ctrl
